// File: rtl/inst_axi_rd_bridge.sv
// SRAM-like instruction fetch port to AXI4 read-only master bridge.
// Single ID, single-beat reads, returned in order; R channel is never back-pressured.

module inst_axi_rd_bridge_chk (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rd_done_i,
  input  logic [1:0] cnt_i
);

  // A completed read must always match an outstanding accepted request.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(rd_done_i && (cnt_i == 2'd0)));

endmodule

module inst_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  ar_state_e   state_q;
  logic [31:0] araddr_q;
  logic [1:0]  arsize_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic        rready_q;
  logic        accept_s;
  logic        rd_done_s;
  logic        unused_ok;

  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

  // Acceptance uses the registered count, so a same-cycle return cannot free a slot early.
  assign accept_s  = (state_q == AR_IDLE) & inst_sram_req & (cnt_q < MAX_CNT);
  assign rd_done_s = rvalid & rready_q & rlast;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept_s, rd_done_s})
      2'b10: cnt_d = cnt_q + 2'd1;
      2'b01: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= AR_IDLE;
      araddr_q <= 32'h0000_0000;
      arsize_q <= 2'b10;
      cnt_q    <= 2'd0;
      rready_q <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      cnt_q    <= cnt_d;
      case (state_q)
        AR_IDLE: begin
          if (accept_s) begin
            araddr_q <= inst_sram_addr;
            arsize_q <= inst_sram_size;
            state_q  <= AR_BUSY;
          end
        end
        AR_BUSY: begin
          if (arready) begin
            state_q <= AR_IDLE;
          end
        end
        default: state_q <= AR_IDLE;
      endcase
    end
  end

  assign inst_sram_addr_ok = accept_s;
  assign inst_sram_data_ok = rd_done_s;
  assign inst_sram_rdata   = rdata;
  assign inst_bus_err      = rd_done_s & (rresp != 2'b00);

  assign arid    = ARID_VAL;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, arsize_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == AR_BUSY);
  assign rready  = rready_q;

  inst_axi_rd_bridge_chk u_chk (
    .clk_i     (clk),
    .reset_i   (reset),
    .rd_done_i (rd_done_s),
    .cnt_i     (cnt_q)
  );

endmodule
